// File: rtl/phase_sequencer.sv
// phase_sequencer: steps each instruction through fetch/exec1/exec2 phases for the decoder,
// latches the fetched word into ir, halts on STP and counts executed instructions.
module phase_sequencer #(
  parameter int FETCH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [15:0]      instr_in,
  output logic [15:0]      ir,
  output logic             fe,
  output logic             e1,
  output logic             e2,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALT} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_fcnt;
  logic [15:0]      r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last, w_stp, w_two, w_run;
  always_comb begin
    w_last = r_fcnt == 3'(FETCH_CYCLES - 1);
    w_stp  = r_ir[15:11] == 5'b00000;
    // ADM/SBM, LDR and LDA need a second execute phase
    w_two  = (r_ir[15:14] == 2'b00 && r_ir[12]) || r_ir[15:11] == 5'b01110 || r_ir[15:13] == 3'b110;
    w_next = r_state == FETCH ? (w_last ? EXEC1 : FETCH) :
             r_state == EXEC1 ? (w_stp ? HALT : w_two ? EXEC2 : FETCH) :
             r_state == EXEC2 ? FETCH : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_fcnt  <= '0;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else if (!hold) begin
      r_state <= w_next;
      if (r_state == FETCH) r_fcnt <= w_last ? 3'd0 : r_fcnt + 3'd1;
      if (r_state == FETCH && w_last) r_ir <= instr_in;
      if (r_state == EXEC1) r_cnt <= r_cnt + 1'b1;
    end
  end
  always_comb begin
    w_run       = ~hold & ~reset;
    fe          = w_run && r_state == FETCH;
    e1          = w_run && r_state == EXEC1;
    e2          = w_run && r_state == EXEC2;
    halted      = r_state == HALT;
    ir          = r_ir;
    instr_count = r_cnt;
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: table-driven check of phase sequencing, hold, halt and reset,
// plus a hand sequence for a three-cycle fetch.
module tb_phase_sequencer;
  logic        clk = 0;
  logic        rst1, hold1, rst3, hold3;
  logic [15:0] din1, din3, ir1, ir3, cnt1, cnt3;
  logic        fe1, e11, e21, hl1, fe3, e13, e23, hl3;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.FETCH_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst1), .hold(hold1), .instr_in(din1), .ir(ir1),
    .fe(fe1), .e1(e11), .e2(e21), .halted(hl1), .instr_count(cnt1));
  phase_sequencer #(.FETCH_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(rst3), .hold(hold3), .instr_in(din3), .ir(ir3),
    .fe(fe3), .e1(e13), .e2(e23), .halted(hl3), .instr_count(cnt3));

  typedef struct {
    logic        rst, hold;
    logic [15:0] din;
    logic [3:0]  ph;
    logic [15:0] ir, cnt;
  } vec_t;
  vec_t tv[$];

  localparam logic [3:0] NO = 4'b0000, FE = 4'b1000, E1 = 4'b0100, E2 = 4'b0010, HL = 4'b0001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic h, input logic [15:0] d,
                     input logic [3:0] p, input logic [15:0] i, input logic [15:0] c);
    tv.push_back('{r, h, d, p, i, c});
  endtask

  task automatic c3(input string nm, input logic [3:0] p, input logic [15:0] i, input logic [15:0] c);
    #1;
    chk({nm, "_ph"}, {fe3, e13, e23, hl3}, p);
    chk({nm, "_ir"}, ir3, i);
    chk({nm, "_cnt"}, cnt3, c);
    step();
  endtask

  initial begin
    add(1, 0, 16'h0800, NO, 16'h0000, 0);
    add(0, 0, 16'h0800, FE, 16'h0000, 0);
    add(0, 0, 16'h0800, E1, 16'h0800, 0);
    add(0, 0, 16'h0800, FE, 16'h0800, 1);
    add(0, 0, 16'h0800, E1, 16'h0800, 1);
    add(0, 0, 16'h0800, FE, 16'h0800, 2);
    add(0, 0, 16'h0800, E1, 16'h0800, 2);
    add(0, 0, 16'h1000, FE, 16'h0800, 3);
    add(0, 0, 16'h1000, E1, 16'h1000, 3);
    add(0, 0, 16'h1000, E2, 16'h1000, 4);
    add(0, 0, 16'hC000, FE, 16'h1000, 4);
    add(0, 0, 16'hC000, E1, 16'hC000, 4);
    add(0, 0, 16'hC000, E2, 16'hC000, 5);
    add(0, 0, 16'h7000, FE, 16'hC000, 5);
    add(0, 0, 16'h7000, E1, 16'h7000, 5);
    add(0, 0, 16'h7000, E2, 16'h7000, 6);
    add(0, 0, 16'hE800, FE, 16'h7000, 6);
    add(0, 0, 16'hE800, E1, 16'hE800, 6);
    add(0, 0, 16'h8000, FE, 16'hE800, 7);
    add(0, 0, 16'h8000, E1, 16'h8000, 7);
    add(0, 0, 16'h0800, FE, 16'h8000, 8);
    add(0, 1, 16'h0800, NO, 16'h0800, 8);
    add(0, 1, 16'h0800, NO, 16'h0800, 8);
    add(0, 1, 16'h0800, NO, 16'h0800, 8);
    add(0, 0, 16'h0800, E1, 16'h0800, 8);
    add(0, 0, 16'h0800, FE, 16'h0800, 9);
    add(1, 0, 16'h0000, NO, 16'h0800, 9);
    add(0, 0, 16'h0000, FE, 16'h0000, 0);
    add(0, 0, 16'h0000, E1, 16'h0000, 0);

    rst1 = 1; hold1 = 0; din1 = 16'h0800;
    rst3 = 1; hold3 = 0; din3 = 16'h0800;
    step();
    foreach (tv[k]) begin
      rst1 = tv[k].rst; hold1 = tv[k].hold; din1 = tv[k].din;
      #1;
      chk($sformatf("v%0d_ph", k), {fe1, e11, e21, hl1}, tv[k].ph);
      chk($sformatf("v%0d_ir", k), ir1, tv[k].ir);
      chk($sformatf("v%0d_cnt", k), cnt1, tv[k].cnt);
      step();
    end

    // halted must be absorbing regardless of hold or input
    for (int i = 0; i < 22; i++) begin
      hold1 = i[0]; din1 = 16'h0800;
      #1;
      chk($sformatf("halt%0d_ph", i), {fe1, e11, e21, hl1}, HL);
      chk($sformatf("halt%0d_cnt", i), cnt1, 16'd1);
      chk($sformatf("halt%0d_ir", i), ir1, 16'h0000);
      step();
    end
    rst1 = 1; hold1 = 0;
    #1;
    chk("halt_rst_ph", {fe1, e11, e21}, 3'b000);
    step();
    rst1 = 0;
    #1;
    chk("post_halt_ph", {fe1, e11, e21, hl1}, FE);
    chk("post_halt_cnt", cnt1, 16'd0);

    rst3 = 0; din3 = 16'h0800;
    c3("f3_c0", FE, 16'h0000, 0);
    hold3 = 1;
    c3("f3_hold", NO, 16'h0000, 0);
    hold3 = 0; din3 = 16'h2000;
    c3("f3_c1", FE, 16'h0000, 0);
    c3("f3_c2", FE, 16'h0000, 0);
    din3 = 16'h1000;
    c3("f3_e1", E1, 16'h2000, 0);
    c3("f3_c0b", FE, 16'h2000, 1);
    c3("f3_c1b", FE, 16'h2000, 1);
    c3("f3_c2b", FE, 16'h2000, 1);
    c3("f3_e1b", E1, 16'h1000, 1);
    rst3 = 1;
    c3("f3_rst_e2", NO, 16'h1000, 2);
    rst3 = 0;
    c3("f3_post", FE, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
